// File: rtl/unstripe_sched.sv
// unstripe_sched: two-lane receive-side merge. Each lane writes into its own
// small FIFO. The heads are popped in strict lane 0 / lane 1 order. Lane skew
// beyond MAX_SKEW stall cycles and writes into a full FIFO raise sticky flags.
module unstripe_sched #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 4,
    parameter int MAX_SKEW = 8
) (
    input  logic              clk_2f,
    input  logic              reset,
    input  logic [DATA_W-1:0] lane_0,
    input  logic              valid_0,
    input  logic [DATA_W-1:0] lane_1,
    input  logic              valid_1,
    input  logic              clr_err,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    output logic              sel_out,
    output logic              active,
    output logic              skew_err,
    output logic              ovf_err
);

    localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam int SW = $clog2(MAX_SKEW + 1);

    typedef enum logic [1:0] {IDLE, RUN, ERR} state_t;

    state_t state, state_nxt;

    logic              exp_lane;   // lane expected to supply the next word
    logic [SW-1:0]     skew_cnt;
    logic [SW-1:0]     skew_inc;

    logic [DATA_W-1:0] din  [2];
    logic [DATA_W-1:0] head [2];
    logic [1:0]        vin;
    logic [1:0]        empty;
    logic [1:0]        full;
    logic [1:0]        pop;
    logic [1:0]        wr_en;
    logic              both_empty;
    logic              pop_ok;
    logic              skew_hit;
    logic              ovf_hit;

    assign din[0] = lane_0;
    assign din[1] = lane_1;
    assign vin    = {valid_1, valid_0};

    // Per-lane FIFO. Pop reads only stored entries, so there is no bypass.
    for (genvar g = 0; g < 2; g++) begin : g_lane
        logic [DATA_W-1:0] mem [DEPTH];
        logic [AW-1:0]     wp;
        logic [AW-1:0]     rp;
        logic [AW:0]       cnt;

        // Storage and pointers; a skew event flushes both lanes together.
        always_ff @(posedge clk_2f) begin
            if (reset || skew_hit) begin
                wp  <= '0;
                rp  <= '0;
                cnt <= '0;
            end else begin
                if (wr_en[g]) begin
                    mem[wp] <= din[g];
                    wp      <= wp + 1'b1;
                end
                if (pop[g]) rp <= rp + 1'b1;
                cnt <= cnt + {{AW{1'b0}}, wr_en[g]} - {{AW{1'b0}}, pop[g]};
            end
        end

        assign empty[g] = (cnt == '0);
        assign full[g]  = (cnt == (AW+1)'(DEPTH));
        assign head[g]  = mem[rp];
    end

    // Pop, skew and write-acceptance decisions, all from registered state.
    always_comb begin
        both_empty = &empty;
        pop_ok     = (state != ERR) && !empty[exp_lane];
        pop        = '0;
        pop[exp_lane] = pop_ok;
        skew_inc   = skew_cnt + 1'b1;
        // Without a pop and with data somewhere, the other lane is holding data.
        skew_hit   = (state != ERR) && !pop_ok && !both_empty &&
                     (skew_inc == SW'(MAX_SKEW));
        wr_en      = '0;
        ovf_hit    = 1'b0;
        if (state != ERR && !skew_hit) begin
            for (int i = 0; i < 2; i++) begin
                if (vin[i]) begin
                    if (!full[i] || pop[i]) wr_en[i] = 1'b1;
                    else                    ovf_hit  = 1'b1;
                end
            end
        end
    end

    // State register.
    always_ff @(posedge clk_2f) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state: IDLE always begins with a lane-0 pop; ERR waits for quiet lanes.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (skew_hit)    state_nxt = ERR;
                else if (pop_ok) state_nxt = RUN;
            end
            RUN: begin
                if (skew_hit)
                    state_nxt = ERR;
                else if (!exp_lane && both_empty && !valid_0 && !valid_1)
                    state_nxt = IDLE;
            end
            ERR: begin
                if (!valid_0 && !valid_1) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign active = (state == RUN);

    // Output register, lane pointer, skew counter and sticky flags.
    always_ff @(posedge clk_2f) begin
        if (reset) begin
            data_out  <= '0;
            valid_out <= 1'b0;
            sel_out   <= 1'b0;
            exp_lane  <= 1'b0;
            skew_cnt  <= '0;
            skew_err  <= 1'b0;
            ovf_err   <= 1'b0;
        end else begin
            valid_out <= pop_ok;
            if (pop_ok) begin
                data_out <= head[exp_lane];
                sel_out  <= exp_lane;
                exp_lane <= ~exp_lane;
            end
            if (skew_hit) begin
                exp_lane <= 1'b0;
                skew_cnt <= '0;
            end else if (pop_ok || both_empty) begin
                skew_cnt <= '0;
            end else begin
                skew_cnt <= skew_inc;
            end
            // A new error on the clearing edge keeps the flag set.
            skew_err <= (skew_err & ~clr_err) | skew_hit;
            ovf_err  <= (ovf_err  & ~clr_err) | ovf_hit;
        end
    end

endmodule

// File: tb/tb_unstripe_sched.sv
// Directed bench for unstripe_sched: a per-cycle vector table (inputs for the
// edge, expected outputs just after it) plus hand-written skew/reset sequences.
module tb_unstripe_sched;

    logic        clk_2f = 1'b0;
    logic        reset;
    logic [31:0] lane_0, lane_1;
    logic        valid_0, valid_1, clr_err;
    logic [31:0] data_out;
    logic        valid_out, sel_out, active, skew_err, ovf_err;

    int n_tests = 0;
    int n_fail  = 0;

    unstripe_sched #(.DATA_W(32), .DEPTH(4), .MAX_SKEW(8)) dut (
        .clk_2f   (clk_2f),
        .reset    (reset),
        .lane_0   (lane_0),
        .valid_0  (valid_0),
        .lane_1   (lane_1),
        .valid_1  (valid_1),
        .clr_err  (clr_err),
        .data_out (data_out),
        .valid_out(valid_out),
        .sel_out  (sel_out),
        .active   (active),
        .skew_err (skew_err),
        .ovf_err  (ovf_err)
    );

    always #5 clk_2f = ~clk_2f;

    typedef struct packed {
        logic        rst;
        logic        v0;
        logic [31:0] d0;
        logic        v1;
        logic [31:0] d1;
        logic        clr;
        logic        evo;
        logic [31:0] edo;
        logic        esel;
        logic        eact;
        logic        eskw;
        logic        eovf;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst, input logic v0, input logic [31:0] d0,
                                input logic v1, input logic [31:0] d1, input logic clr,
                                input logic evo, input logic [31:0] edo, input logic esel,
                                input logic eact, input logic eskw, input logic eovf);
        vec_t v;
        v.rst = rst; v.v0 = v0; v.d0 = d0; v.v1 = v1; v.d1 = d1; v.clr = clr;
        v.evo = evo; v.edo = edo; v.esel = esel; v.eact = eact; v.eskw = eskw; v.eovf = eovf;
        return v;
    endfunction

    function automatic void add(input logic rst, input logic v0, input logic [31:0] d0,
                                input logic v1, input logic [31:0] d1, input logic clr,
                                input logic evo, input logic [31:0] edo, input logic esel,
                                input logic eact, input logic eskw, input logic eovf);
        vecs.push_back(mk(rst, v0, d0, v1, d1, clr, evo, edo, esel, eact, eskw, eovf));
    endfunction

    // Drive one edge worth of inputs, then check outputs 1 time unit after it.
    task automatic apply(input vec_t v, input int idx);
        reset = v.rst; valid_0 = v.v0; lane_0 = v.d0;
        valid_1 = v.v1; lane_1 = v.d1; clr_err = v.clr;
        @(posedge clk_2f);
        #1;
        n_tests++;
        if (valid_out !== v.evo || data_out !== v.edo || sel_out !== v.esel ||
            active !== v.eact || skew_err !== v.eskw || ovf_err !== v.eovf) begin
            n_fail++;
            $display("FAIL vec%0d: got vo=%b do=%h sel=%b act=%b skew=%b ovf=%b, want vo=%b do=%h sel=%b act=%b skew=%b ovf=%b",
                     idx, valid_out, data_out, sel_out, active, skew_err, ovf_err,
                     v.evo, v.edo, v.esel, v.eact, v.eskw, v.eovf);
        end
    endtask

    int hidx = 1000;

    task automatic step(input logic rst, input logic v0, input logic [31:0] d0,
                        input logic v1, input logic [31:0] d1, input logic clr,
                        input logic evo, input logic [31:0] edo, input logic esel,
                        input logic eact, input logic eskw, input logic eovf);
        apply(mk(rst, v0, d0, v1, d1, clr, evo, edo, esel, eact, eskw, eovf), hidx);
        hidx++;
    endtask

    initial begin
        reset = 1'b1; valid_0 = 1'b0; valid_1 = 1'b0;
        lane_0 = '0; lane_1 = '0; clr_err = 1'b0;

        // reset state
        add(1,0,0,0,0,0,       0,0,0,0,0,0);
        add(1,0,0,0,0,0,       0,0,0,0,0,0);
        // aligned lanes, pairs on alternate cycles
        add(0,1,'hA0,1,'hA1,0, 0,0,0,0,0,0);
        add(0,0,0,0,0,0,       1,'hA0,0,1,0,0);
        add(0,1,'hA2,1,'hA3,0, 1,'hA1,1,1,0,0);
        add(0,0,0,0,0,0,       1,'hA2,0,1,0,0);
        add(0,1,'hA4,1,'hA5,0, 1,'hA3,1,1,0,0);
        add(0,0,0,0,0,0,       1,'hA4,0,1,0,0);
        add(0,0,0,0,0,0,       1,'hA5,1,1,0,0);
        add(0,0,0,0,0,0,       0,'hA5,1,0,0,0);
        // lane 1 leads by 3 cycles
        add(0,0,0,1,'hB1,0,    0,'hA5,1,0,0,0);
        add(0,0,0,0,0,0,       0,'hA5,1,0,0,0);
        add(0,0,0,0,0,0,       0,'hA5,1,0,0,0);
        add(0,1,'hB0,0,0,0,    0,'hA5,1,0,0,0);
        add(0,0,0,0,0,0,       1,'hB0,0,1,0,0);
        add(0,0,0,0,0,0,       1,'hB1,1,1,0,0);
        add(0,0,0,0,0,0,       0,'hB1,1,0,0,0);
        // overflow: E0 moves the pointer to lane 1, then E1..E5 fill lane 0
        add(0,1,'hE0,0,0,0,    0,'hB1,1,0,0,0);
        add(0,1,'hE1,0,0,0,    1,'hE0,0,1,0,0);
        add(0,1,'hE2,0,0,0,    0,'hE0,0,1,0,0);
        add(0,1,'hE3,0,0,0,    0,'hE0,0,1,0,0);
        add(0,1,'hE4,0,0,0,    0,'hE0,0,1,0,0);
        add(0,1,'hE5,0,0,0,    0,'hE0,0,1,0,1);
        add(0,0,0,1,'hF1,1,    0,'hE0,0,1,0,0);
        // clr_err on the same edge as a new overflow (E6 into full lane 0)
        add(0,1,'hE6,1,'hF2,1, 1,'hF1,1,1,0,1);
        add(0,0,0,1,'hF3,1,    1,'hE1,0,1,0,0);
        add(0,0,0,1,'hF4,0,    1,'hF2,1,1,0,0);
        add(0,0,0,1,'hF5,0,    1,'hE2,0,1,0,0);
        add(0,0,0,0,0,0,       1,'hF3,1,1,0,0);
        add(0,0,0,0,0,0,       1,'hE3,0,1,0,0);
        add(0,0,0,0,0,0,       1,'hF4,1,1,0,0);
        add(0,0,0,0,0,0,       1,'hE4,0,1,0,0);
        add(0,0,0,0,0,0,       1,'hF5,1,1,0,0);
        add(0,0,0,0,0,0,       0,'hF5,1,0,0,0);

        foreach (vecs[i]) apply(vecs[i], i);

        // skew: lone lane-1 word in IDLE; 8th stall edge trips the error
        step(0,0,0,1,'h51,0,      0,'hF5,1,0,0,0);
        for (int k = 0; k < 7; k++)
            step(0,0,0,0,0,0,     0,'hF5,1,0,0,0);
        step(0,1,'h5A,0,0,0,      0,'hF5,1,0,1,0);   // discarded on the error edge
        step(0,1,'h5B,1,'h5C,0,   0,'hF5,1,0,1,0);   // ERR discards writes
        step(0,0,0,1,'h5D,0,      0,'hF5,1,0,1,0);
        step(0,0,0,0,0,0,         0,'hF5,1,0,1,0);   // quiet cycle -> IDLE
        step(0,1,'hD0,1,'hD1,0,   0,'hF5,1,0,1,0);
        step(0,0,0,0,0,0,         1,'hD0,0,1,1,0);
        step(0,0,0,0,0,0,         1,'hD1,1,1,1,0);
        step(0,0,0,0,0,0,         0,'hD1,1,0,1,0);

        // reset mid-stream with two words buffered
        step(0,1,'hC8,0,0,0,      0,'hD1,1,0,1,0);
        step(0,1,'hCA,1,'hC9,0,   1,'hC8,0,1,1,0);
        step(1,0,0,0,0,0,         0,0,0,0,0,0);
        step(0,0,0,0,0,0,         0,0,0,0,0,0);
        step(0,1,'hC0,1,'hC1,0,   0,0,0,0,0,0);
        step(0,0,0,0,0,0,         1,'hC0,0,1,0,0);
        step(0,0,0,0,0,0,         1,'hC1,1,1,0,0);
        step(0,0,0,0,0,0,         0,'hC1,1,0,0,0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
